// File: rtl/ace_snapshot_loader.sv
`default_nettype none
// ============================================================================
// ace_snapshot_loader
// Turns a .ace snapshot byte stream into write strobes for the Ace core
// loader port. RLE decompression (ESC/count/byte) is built when ACE_RLE_EN
// is defined.
// Revision: 1.0
// ============================================================================
module ace_snapshot_loader #(
    parameter logic [15:0] BASE_ADDR = 16'h2000,
    parameter logic [7:0]  ESC_BYTE  = 8'hED
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        download,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    output logic        loader_en,
    output logic [15:0] loader_addr,
    output logic [7:0]  loader_data,
    output logic        loader_wr,
    output logic        done,
    output logic        overflow
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LIT  = 3'd1;
`ifdef ACE_RLE_EN
    localparam logic [2:0] S_ESC  = 3'd2;
    localparam logic [2:0] S_CNT  = 3'd3;
    localparam logic [2:0] S_RUN  = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;
`endif

    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    logic        r_dl_q;
    logic        r_en;
    logic        r_wr;
    logic        r_done;
    logic        r_ovf;
    logic        r_full;
    logic [15:0] r_ptr;
    logic [15:0] r_addr;
    logic [7:0]  r_data;

    logic        w_accept;
    logic        w_start;
    logic        w_stop;
    logic        w_emit;
    logic        w_set_done;
    logic [7:0]  w_emit_data;

`ifdef ACE_RLE_EN
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_nxt;
    logic [7:0]  r_run_byte;
    logic [7:0]  w_run_nxt;

    assign in_ready = (r_state != S_RUN);
`else
    assign in_ready = 1'b1;
`endif

    assign w_accept    = in_valid & in_ready;
    assign loader_en   = r_en;
    assign loader_addr = r_addr;
    assign loader_data = r_data;
    assign loader_wr   = r_wr;
    assign done        = r_done;
    assign overflow    = r_ovf;

    // A run ignores the download level until its last strobe; every other
    // active state drops back to IDLE as soon as download is seen low.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_stop      = 1'b0;
        w_emit      = 1'b0;
        w_emit_data = in_data;
        w_set_done  = 1'b0;
`ifdef ACE_RLE_EN
        w_cnt_nxt   = r_cnt;
        w_run_nxt   = r_run_byte;
`endif
        case (r_state)
            S_IDLE: begin
                if (download && !r_dl_q) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_LIT;
                end
            end
            S_LIT: begin
                if (!download) begin
                    w_stop      = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (w_accept) begin
`ifdef ACE_RLE_EN
                    if (in_data == ESC_BYTE) begin
                        w_state_nxt = S_ESC;
                    end else begin
                        w_emit = 1'b1;
                    end
`else
                    w_emit = 1'b1;
`endif
                end
            end
`ifdef ACE_RLE_EN
            S_ESC: begin
                if (!download) begin
                    w_stop      = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (w_accept) begin
                    if (in_data == 8'd0) begin
                        w_set_done  = 1'b1;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_cnt_nxt   = in_data;
                        w_state_nxt = S_CNT;
                    end
                end
            end
            S_CNT: begin
                if (!download) begin
                    w_stop      = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (w_accept) begin
                    // First strobe of the run goes out with the value byte itself.
                    w_run_nxt   = in_data;
                    w_emit      = 1'b1;
                    w_cnt_nxt   = r_cnt - 8'd1;
                    w_state_nxt = (r_cnt == 8'd1) ? S_LIT : S_RUN;
                end
            end
            S_RUN: begin
                w_emit      = 1'b1;
                w_emit_data = r_run_byte;
                w_cnt_nxt   = r_cnt - 8'd1;
                if (r_cnt == 8'd1) begin
                    w_state_nxt = S_LIT;
                end
            end
            S_DONE: begin
                if (!download) begin
                    w_stop      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
`endif
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_dl_q  <= 1'b0;
            r_en    <= 1'b0;
            r_wr    <= 1'b0;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
            r_full  <= 1'b0;
            r_ptr   <= BASE_ADDR;
            r_addr  <= 16'h0000;
            r_data  <= 8'h00;
`ifdef ACE_RLE_EN
            r_cnt      <= 8'h00;
            r_run_byte <= 8'h00;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_dl_q  <= download;
            r_wr    <= w_emit & ~r_full;
`ifdef ACE_RLE_EN
            r_cnt      <= w_cnt_nxt;
            r_run_byte <= w_run_nxt;
`endif
            if (w_start) begin
                r_en   <= 1'b1;
                r_ptr  <= BASE_ADDR;
                r_full <= 1'b0;
                r_done <= 1'b0;
                r_ovf  <= 1'b0;
            end else if (w_stop) begin
                r_en <= 1'b0;
            end
            if (w_set_done) begin
                r_done <= 1'b1;
            end
            // r_full marks that 0xFFFF itself has been written; the pointer
            // saturates there and later writes are dropped.
            if (w_emit) begin
                if (r_full) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_addr <= r_ptr;
                    r_data <= w_emit_data;
                    if (r_ptr == 16'hFFFF) begin
                        r_full <= 1'b1;
                    end else begin
                        r_ptr <= r_ptr + 16'd1;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ace_snapshot_loader.sv
`default_nettype none
// ============================================================================
// tb_ace_snapshot_loader
// Drives directed and random snapshot streams into two loaders (normal base
// and a base near the top of memory) and checks them against a stream model.
// Revision: 1.0
// ============================================================================
module tb_ace_snapshot_loader;

    localparam int BASE_A = 32'h2000;
    localparam int BASE_B = 32'hFFFE;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        download;
    logic        in_valid;
    logic [7:0]  in_data;

    logic        in_ready_a, in_ready_b;
    logic        en_a, en_b, wr_a, wr_b, done_a, done_b, ovf_a, ovf_b;
    logic [15:0] addr_a, addr_b;
    logic [7:0]  data_a, data_b;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          lowcnt = 0;

    logic [7:0]  stim[$];
    logic [7:0]  dec[$];
    logic [23:0] act_a[$];
    logic [23:0] act_b[$];
    int          st_a[$];
    bit          exp_done;
    int          exp_low;

    ace_snapshot_loader #(.BASE_ADDR(16'h2000), .ESC_BYTE(8'hED)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .download(download),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
        .loader_en(en_a), .loader_addr(addr_a), .loader_data(data_a),
        .loader_wr(wr_a), .done(done_a), .overflow(ovf_a)
    );

    ace_snapshot_loader #(.BASE_ADDR(16'hFFFE), .ESC_BYTE(8'hED)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .download(download),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
        .loader_en(en_b), .loader_addr(addr_b), .loader_data(data_b),
        .loader_wr(wr_b), .done(done_b), .overflow(ovf_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wr_a) begin
            act_a.push_back({addr_a, data_a});
            st_a.push_back(cyc);
        end
        if (wr_b) act_b.push_back({addr_b, data_b});
        if (!in_ready_a) lowcnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Decodes the stimulus stream into the byte sequence that must land in memory.
    task automatic build_model();
        int i;
        int n;
        dec.delete();
        exp_done = 1'b0;
        exp_low  = 0;
        i = 0;
        while (i < stim.size()) begin
`ifdef ACE_RLE_EN
            if (stim[i] == 8'hED) begin
                n = int'(stim[i+1]);
                if (n == 0) begin
                    exp_done = 1'b1;
                    break;
                end
                for (int r = 0; r < n; r++) dec.push_back(stim[i+2]);
                exp_low += n - 1;
                i += 3;
            end else begin
                dec.push_back(stim[i]);
                i++;
            end
`else
            dec.push_back(stim[i]);
            i++;
`endif
        end
    endtask

    task automatic check_writes(input string tag, input int base, input int lim,
                                input logic [23:0] act[$]);
        int n;
        n = dec.size();
        if (lim < n) n = lim;
        if (65536 - base < n) n = 65536 - base;
        chk({tag, "/nwrites"}, 32'(act.size()), 32'(n));
        for (int i = 0; i < n && i < act.size(); i++)
            chk({tag, "/write"}, 32'(act[i]), 32'({16'(base + i), dec[i]}));
    endtask

    function automatic bit exp_ovf(input int base);
        return (base + dec.size()) > 65536;
    endfunction

    task automatic send(input logic [7:0] b);
        logic acc;
        acc = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        for (int k = 0; k < 400; k++) begin
            acc = in_ready_a;
            tick();
            if (acc) break;
        end
        in_valid = 1'b0;
        chk("send/accepted", 32'(acc), 32'd1);
    endtask

    task automatic session(input string tag, input int gap_max, input bit contig);
        int w;
        build_model();
        act_a.delete();
        act_b.delete();
        st_a.delete();
        lowcnt = 0;
        download = 1'b1;
        tick();
        chk({tag, "/en_rise_a"}, 32'(en_a), 32'd1);
        chk({tag, "/done_clr_b"}, 32'(done_b), 32'd0);
        chk({tag, "/ovf_clr_b"}, 32'(ovf_b), 32'd0);
        foreach (stim[j]) begin
            send(stim[j]);
            w = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
            repeat (w) tick();
        end
        w = 0;
        while (!in_ready_a && w < 400) begin
            tick();
            w++;
        end
        tick();
        tick();
        chk({tag, "/en_hold_a"}, 32'(en_a), 32'd1);
        chk({tag, "/en_hold_b"}, 32'(en_b), 32'd1);
        chk({tag, "/done_a"}, 32'(done_a), 32'(exp_done));
        chk({tag, "/done_b"}, 32'(done_b), 32'(exp_done));
        chk({tag, "/ovf_a"}, 32'(ovf_a), 32'(exp_ovf(BASE_A)));
        chk({tag, "/ovf_b"}, 32'(ovf_b), 32'(exp_ovf(BASE_B)));
        chk({tag, "/ready_low"}, 32'(lowcnt), 32'(exp_low));
        if (contig && st_a.size() > 0)
            chk({tag, "/contig"}, 32'(st_a[st_a.size()-1] - st_a[0]), 32'(st_a.size() - 1));
        download = 1'b0;
        tick();
        chk({tag, "/en_fall_a"}, 32'(en_a), 32'd0);
        chk({tag, "/en_fall_b"}, 32'(en_b), 32'd0);
        chk({tag, "/done_sticky"}, 32'(done_a), 32'(exp_done));
        tick();
        check_writes({tag, "/a"}, BASE_A, 1 << 20, act_a);
        check_writes({tag, "/b"}, BASE_B, 1 << 20, act_b);
    endtask

    task automatic rand_stream(input int ntok, input bit with_end);
        logic [7:0] b;
        stim.delete();
        for (int t = 0; t < ntok; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                stim.push_back(8'hED);
                stim.push_back(8'($urandom_range(1, 9)));
                stim.push_back(8'($urandom));
            end else begin
                b = 8'($urandom);
                if (b == 8'hED) b = 8'h00;
                stim.push_back(b);
            end
        end
        if (with_end) begin
            stim.push_back(8'hED);
            stim.push_back(8'h00);
            stim.push_back(8'($urandom));
            stim.push_back(8'($urandom));
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "/wr_a"}, 32'(wr_a), 32'd0);
        chk({tag, "/en_a"}, 32'(en_a), 32'd0);
        chk({tag, "/ready_a"}, 32'(in_ready_a), 32'd1);
        chk({tag, "/done_a"}, 32'(done_a), 32'd0);
        chk({tag, "/ovf_b"}, 32'(ovf_b), 32'd0);
        chk({tag, "/addr_a"}, 32'(addr_a), 32'd0);
        chk({tag, "/data_a"}, 32'(data_a), 32'd0);
        chk({tag, "/wr_b"}, 32'(wr_b), 32'd0);
    endtask

    initial begin
        int k;
        reset_n  = 1'b0;
        download = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) tick();
        check_reset_state("reset");
        reset_n = 1'b1;
        tick();

        // stray byte while download is low
        act_a.delete();
        send(8'h5A);
        tick();
        tick();
        chk("stray/nwrites", 32'(act_a.size()), 32'd0);
        chk("stray/en", 32'(en_a), 32'd0);

        stim = '{8'h11, 8'h22, 8'h33};
        session("lit", 0, 1'b1);
        stim = '{8'hED, 8'h05, 8'hAA, 8'h44};
        session("run", 0, 1'b1);
        stim = '{8'h01, 8'hED, 8'h00, 8'h99};
        session("end", 0, 1'b0);
        stim = '{8'hED, 8'h04, 8'h55};
        session("ovf", 0, 1'b0);
        stim = '{8'hED, 8'h01, 8'h3C, 8'hED, 8'h02, 8'h4D, 8'h7E};
        session("short_runs", 0, 1'b1);

        rand_stream(20, 1'b0);
        session("rand0", 2, 1'b0);
        rand_stream(25, 1'b1);
        session("rand1", 1, 1'b0);
        rand_stream(30, 1'b0);
        session("rand2", 0, 1'b0);

        // reset during the tenth write strobe
        act_a.delete();
        act_b.delete();
        download = 1'b1;
        tick();
`ifdef ACE_RLE_EN
        stim = '{8'hED, 8'hFF, 8'h00};
        build_model();
        foreach (stim[j]) send(stim[j]);
        k = 0;
        for (int c = 0; c < 300; c++) begin
            if (wr_a) k++;
            if (k == 10) break;
            tick();
        end
`else
        stim.delete();
        for (int j = 0; j < 10; j++) stim.push_back(8'($urandom));
        build_model();
        foreach (stim[j]) send(stim[j]);
        k = 0;
        for (int c = 0; c < 10; c++) k += int'(st_a.size() > c);
        k = (wr_a && k == 9) ? 10 : k;
`endif
        chk("rst/reach10", 32'(k), 32'd10);
        reset_n  = 1'b0;
        download = 1'b0;
        tick();
        check_reset_state("rst");
        reset_n = 1'b1;
        tick();
        tick();
        check_writes("rst/a", BASE_A, 10, act_a);
        check_writes("rst/b", BASE_B, 10, act_b);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
